// File: rtl/midi_merge_arb.sv
// rtl/midi_merge_arb.sv - message-granular round-robin MIDI merger with running-status regeneration.
// Optional realtime bypass of the current lock: define MIDI_ARB_RT_BYPASS_EN.
module midi_merge_arb #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_empty_n_i,
    output logic [NUM_REQ-1:0]     req_rd_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_wr_o,
    input  logic                   tx_full_n_i,
    output logic [NUM_REQ-1:0]     grant_o
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_RSINS, S_XFER, S_SYSEX} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         out_rs_q, out_rs_d;
    logic [7:0]         rs_q [NUM_REQ];
    logic [7:0]         rs_d [NUM_REQ];
    logic [1:0]         cnt_q, cnt_d;
    logic [15:0]        idle_q, idle_d;

    logic [7:0]         head;
    logic               avail;
    logic               head_rt;
    logic               head_status_nrt;
    logic               pick_vld;
    logic [IW-1:0]      pick;
    logic               byp_vld;
    logic [IW-1:0]      byp_idx;
    logic               rel;

    // Status 8'h00 is never a valid status, so it doubles as "no running status".
    function automatic logic [1:0] msg_len(input logic [7:0] s);
        case (s[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd2;
            4'hC, 4'hD:                   msg_len = 2'd1;
            4'hF: begin
                case (s[3:0])
                    4'h2:       msg_len = 2'd2;
                    4'h1, 4'h3: msg_len = 2'd1;
                    default:    msg_len = 2'd0;
                endcase
            end
            default:                      msg_len = 2'd0;
        endcase
    endfunction

    assign head            = req_data_i[8*int'(owner_q) +: 8];
    assign avail           = req_empty_n_i[owner_q];
    assign head_rt         = (head[7:3] == 5'h1F);
    assign head_status_nrt = head[7] && !head_rt;
    assign grant_o         = grant_q;

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && req_empty_n_i[(int'(rr_q) + i) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick     = IW'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        byp_vld = 1'b0;
        byp_idx = '0;
`ifdef MIDI_ARB_RT_BYPASS_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!byp_vld && (IW'(k) != owner_q) && req_empty_n_i[k] &&
                (req_data_i[8*k+3 +: 5] == 5'h1F)) begin
                byp_vld = 1'b1;
                byp_idx = IW'(k);
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        out_rs_d  = out_rs_q;
        rs_d      = rs_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        req_rd_o  = '0;
        tx_wr_o   = 1'b0;
        tx_data_o = 8'h00;
        rel       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    state_d       = S_HEAD;
                end
            end
            S_HEAD: begin
                if (avail && tx_full_n_i) begin
                    if (head_rt) begin
                        req_rd_o[owner_q] = 1'b1;
                        tx_wr_o           = 1'b1;
                        tx_data_o         = head;
                        rel               = 1'b1;
                    end else if (head[7]) begin
                        req_rd_o[owner_q] = 1'b1;
                        tx_wr_o           = 1'b1;
                        tx_data_o         = head;
                        cnt_d             = msg_len(head);
                        idle_d            = 16'd0;
                        if (head[7:4] != 4'hF) begin
                            rs_d[owner_q] = head;
                            out_rs_d      = head;
                        end else begin
                            out_rs_d      = 8'h00;
                        end
                        if (head == 8'hF0)              state_d = S_SYSEX;
                        else if (msg_len(head) == 2'd0) rel     = 1'b1;
                        else                            state_d = S_XFER;
                    end else if (rs_q[owner_q] == 8'h00) begin
                        req_rd_o[owner_q] = 1'b1;
                        rel               = 1'b1;
                    end else if (rs_q[owner_q] != out_rs_q) begin
                        state_d = S_RSINS;
                    end else begin
                        cnt_d   = msg_len(rs_q[owner_q]);
                        idle_d  = 16'd0;
                        state_d = S_XFER;
                    end
                end
            end
            S_RSINS: begin
                if (tx_full_n_i) begin
                    tx_wr_o   = 1'b1;
                    tx_data_o = rs_q[owner_q];
                    out_rs_d  = rs_q[owner_q];
                    cnt_d     = msg_len(rs_q[owner_q]);
                    idle_d    = 16'd0;
                    state_d   = S_XFER;
                end
            end
            S_XFER, S_SYSEX: begin
                if (byp_vld && tx_full_n_i) begin
                    req_rd_o[byp_idx] = 1'b1;
                    tx_wr_o           = 1'b1;
                    tx_data_o         = req_data_i[8*int'(byp_idx) +: 8];
                end else if (avail) begin
                    // An unexpected status ends the message; it stays queued for the next HEAD.
                    if (head_status_nrt && !(state_q == S_SYSEX && head == 8'hF7)) begin
                        rel = 1'b1;
                    end else if (tx_full_n_i) begin
                        req_rd_o[owner_q] = 1'b1;
                        tx_wr_o           = 1'b1;
                        tx_data_o         = head;
                        idle_d            = 16'd0;
                        if (state_q == S_SYSEX) begin
                            if (head == 8'hF7) rel = 1'b1;
                        end else if (!head_rt) begin
                            cnt_d = cnt_q - 2'd1;
                            if (cnt_q == 2'd1) rel = 1'b1;
                        end
                    end
                end else if (tx_full_n_i) begin
                    idle_d = idle_q + 16'd1;
                    if (idle_d == TIMEOUT) begin
                        rel      = 1'b1;
                        out_rs_d = 8'h00;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rel) begin
            grant_d = '0;
            rr_d    = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            grant_q  <= '0;
            out_rs_q <= 8'h00;
            cnt_q    <= 2'd0;
            idle_q   <= 16'd0;
            for (int k = 0; k < NUM_REQ; k++) rs_q[k] <= 8'h00;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            out_rs_q <= out_rs_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            rs_q     <= rs_d;
        end
    end
endmodule

// File: tb/tb_midi_merge_arb.sv
// tb/tb_midi_merge_arb.sv - directed and randomized bench for midi_merge_arb against a message-level model.
module tb_midi_merge_arb;
    localparam int N   = 4;
    localparam int TMO = 4096;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0]   req_empty_n_i = '0;
    logic [N-1:0]   req_rd_o;
    logic [7:0]     tx_data_o;
    logic           tx_wr_o;
    logic           tx_full_n_i = 1'b1;
    logic [N-1:0]   grant_o;

    always #5 clk = ~clk;

    midi_merge_arb #(.NUM_REQ(N), .TIMEOUT(16'd4096)) dut (
        .clk(clk), .reset_n(reset_n), .req_data_i(req_data_i), .req_empty_n_i(req_empty_n_i),
        .req_rd_o(req_rd_o), .tx_data_o(tx_data_o), .tx_wr_o(tx_wr_o),
        .tx_full_n_i(tx_full_n_i), .grant_o(grant_o)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] fmem [N][256];
    int         fhd [N];
    int         ftl [N];
    logic [7:0] mmem [N][256];
    int         mhd [N];
    int         mtl [N];
    logic [7:0] m_rs [N];
    logic [7:0] m_out_rs;
    int         m_rr;
    logic [7:0] gen_rs [N];
    logic [7:0] expq[$];
    logic [7:0] txq[$];
    logic [7:0] cl[$];
    int         txt[$];
    logic [N-1:0] glog[$];
    logic [N-1:0] last_grant;
    int tick_no  = 0;
    int full_pct = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tb_len(input logic [7:0] s);
        if (s >= 8'h80 && s <= 8'hBF) return 2;
        if (s >= 8'hC0 && s <= 8'hDF) return 1;
        if (s >= 8'hE0 && s <= 8'hEF) return 2;
        if (s == 8'hF2) return 2;
        if (s == 8'hF1 || s == 8'hF3) return 1;
        return 0;
    endfunction

    function automatic logic all_empty();
        for (int k = 0; k < N; k++) if (fhd[k] < ftl[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_empty_n_i[k]     = (fhd[k] < ftl[k]);
            req_data_i[8*k +: 8] = (fhd[k] < ftl[k]) ? fmem[k][fhd[k]] : 8'h00;
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        if (fhd[k] == ftl[k]) begin fhd[k] = 0; ftl[k] = 0; end
        if (mhd[k] == mtl[k]) begin mhd[k] = 0; mtl[k] = 0; end
        fmem[k][ftl[k]] = b; ftl[k]++;
        mmem[k][mtl[k]] = b; mtl[k]++;
    endtask

    function automatic logic [7:0] mpop(input int k);
        logic [7:0] v;
        v = mmem[k][mhd[k]];
        mhd[k]++;
        return v;
    endfunction

    // Whole messages at a time: pick the next owner, emit its message, advance the pointer.
    task automatic model_run();
        int k;
        logic [7:0] b;
        logic [7:0] x;
        forever begin
            k = -1;
            for (int i = 0; i < N; i++)
                if (k < 0 && mhd[(m_rr + i) % N] < mtl[(m_rr + i) % N]) k = (m_rr + i) % N;
            if (k < 0) break;
            b = mpop(k);
            if (b >= 8'hF8) begin
                expq.push_back(b);
            end else if (b >= 8'h80) begin
                expq.push_back(b);
                if (b < 8'hF0) begin m_rs[k] = b; m_out_rs = b; end
                else m_out_rs = 8'h00;
                if (b == 8'hF0) begin
                    do begin x = mpop(k); expq.push_back(x); end while (x != 8'hF7);
                end else begin
                    for (int j = 0; j < tb_len(b); j++) expq.push_back(mpop(k));
                end
            end else if (m_rs[k] != 8'h00) begin
                if (m_rs[k] != m_out_rs) begin expq.push_back(m_rs[k]); m_out_rs = m_rs[k]; end
                expq.push_back(b);
                for (int j = 1; j < tb_len(m_rs[k]); j++) expq.push_back(mpop(k));
            end
            m_rr = (k + 1) % N;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("rd_onehot", int'($countones(req_rd_o) <= 1), 1);
        chk("rd_nonempty", int'(|(req_rd_o & ~req_empty_n_i)), 0);
        chk("wr_while_full", int'(tx_wr_o & ~tx_full_n_i), 0);
        if (tx_wr_o) begin txq.push_back(tx_data_o); txt.push_back(tick_no); end
        for (int k = 0; k < N; k++) if (req_rd_o[k] && fhd[k] < ftl[k]) fhd[k]++;
        if (grant_o != last_grant) begin
            if (grant_o != '0) glog.push_back(grant_o);
            last_grant = grant_o;
        end
        @(posedge clk);
        #1;
        tick_no++;
        tx_full_n_i = ($urandom_range(99) >= full_pct);
        drive();
    endtask

    task automatic run_drain(input string tag, input int bound);
        int n = 0;
        while (!(all_empty() && grant_o == '0) && n < bound) begin tick(); n++; end
        chk({tag, "_drained"}, int'(all_empty() && grant_o == '0), 1);
    endtask

    task automatic run_txn(input string tag, input int cnt, input int bound);
        int n = 0;
        while (txq.size() < cnt && n < bound) begin tick(); n++; end
        chk({tag, "_txcount"}, txq.size(), cnt);
    endtask

    task automatic cmp_q(input string tag, input logic [7:0] ref_q[$]);
        chk({tag, "_len"}, txq.size(), ref_q.size());
        for (int i = 0; i < txq.size() && i < ref_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), int'(txq[i]), int'(ref_q[i]));
    endtask

    task automatic phase(input string tag, input bit use_const);
        model_run();
        run_drain(tag, 2000);
        if (use_const) cmp_q({tag, "_const"}, cl);
        cmp_q({tag, "_model"}, expq);
        txq.delete(); txt.delete(); expq.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_grant", int'(grant_o), 0);
        chk("rst_wr", int'(tx_wr_o), 0);
        chk("rst_rd", int'(req_rd_o), 0);
        chk("rst_data", int'(tx_data_o), 0);
        for (int k = 0; k < N; k++) begin
            fhd[k] = 0; ftl[k] = 0; mhd[k] = 0; mtl[k] = 0;
            m_rs[k] = 8'h00; gen_rs[k] = 8'h00;
        end
        m_out_rs = 8'h00; m_rr = 0;
        tx_full_n_i = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        last_grant = '0;
        txq.delete(); txt.delete(); expq.delete(); glog.delete();
    endtask

    task automatic gen_msg(input int k);
        int t;
        logic [7:0] s;
        t = $urandom_range(0, 5);
        if (t == 0 || t == 5) begin
            s = 8'h80 | 8'($urandom_range(0, 6) << 4) | 8'($urandom_range(0, 15));
            push(k, s); gen_rs[k] = s;
            for (int j = 0; j < tb_len(s); j++) push(k, 8'($urandom_range(0, 127)));
        end else if (t == 1) begin
            if (gen_rs[k] == 8'h00) push(k, 8'($urandom_range(0, 127)));
            else for (int j = 0; j < tb_len(gen_rs[k]); j++) push(k, 8'($urandom_range(0, 127)));
        end else if (t == 2) begin
            push(k, 8'hF8 | 8'($urandom_range(0, 7)));
        end else if (t == 3) begin
            push(k, 8'hF0);
            repeat ($urandom_range(0, 3)) push(k, 8'($urandom_range(0, 127)));
            push(k, 8'hF7);
        end else begin
            case ($urandom_range(0, 3))
                0: s = 8'hF1;
                1: s = 8'hF2;
                2: s = 8'hF3;
                default: s = 8'hF6;
            endcase
            push(k, s);
            for (int j = 0; j < tb_len(s); j++) push(k, 8'($urandom_range(0, 127)));
        end
    endtask

    initial begin
        int start;
        for (int k = 0; k < N; k++) begin fhd[k] = 0; ftl[k] = 0; mhd[k] = 0; mtl[k] = 0; end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h40);
        push(1, 8'hC5); push(1, 8'h07);
        drive();
        start = tick_no;
        model_run();
        run_drain("t1", 200);
        chk("t1_first_wr_latency", txt.size() > 0 ? txt[0] - start : -1, 1);
        chk("t1_grant_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t1_grant0", int'(glog[0]), 1);
            chk("t1_grant1", int'(glog[1]), 2);
        end
        cl = '{8'h90, 8'h3C, 8'h40, 8'hC5, 8'h07};
        cmp_q("t1_const", cl);
        cmp_q("t1_model", expq);
        txq.delete(); txt.delete(); expq.delete();

        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h40); push(0, 8'h3E); push(0, 8'h40);
        drive();
        cl = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40};
        phase("t2", 1'b1);

        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h40); drive();
        cl = '{8'h90, 8'h3C, 8'h40};
        phase("t3a", 1'b1);
        push(1, 8'h80); push(1, 8'h3C); push(1, 8'h00); drive();
        cl = '{8'h80, 8'h3C, 8'h00};
        phase("t3b", 1'b1);
        push(0, 8'h3E); push(0, 8'h40); drive();
        cl = '{8'h90, 8'h3E, 8'h40};
        phase("t3c", 1'b1);

        do_reset();
        push(2, 8'h3C); push(2, 8'h40); drive();
        cl.delete();
        phase("t4_orphan", 1'b1);

        do_reset();
        push(0, 8'hF0); drive();
        run_txn("byp_f0", 1, 20);
        push(1, 8'hF8); push(0, 8'h01); push(0, 8'h02); push(0, 8'hF7); drive();
        run_drain("byp", 100);
`ifdef MIDI_ARB_RT_BYPASS_EN
        cl = '{8'hF0, 8'hF8, 8'h01, 8'h02, 8'hF7};
`else
        cl = '{8'hF0, 8'h01, 8'h02, 8'hF7, 8'hF8};
`endif
        cmp_q("byp", cl);
        txq.delete(); txt.delete();

        push(0, 8'h90); drive();
        tick(); tick();
        chk("pre_reset_grant", int'(grant_o), 1);
        do_reset();

        push(0, 8'hF0); push(0, 8'h7E); push(0, 8'h01);
        push(1, 8'hC0); push(1, 8'h05);
        drive();
        run_txn("tmo", 4, TMO + 200);
        if (txq.size() >= 4) begin
            cl = '{8'hF0, 8'h7E, 8'h01, 8'hC0};
            for (int i = 0; i < 4; i++) chk($sformatf("tmo_b%0d", i), int'(txq[i]), int'(cl[i]));
            chk("tmo_delay_min", int'(txt[3] - txt[2] >= TMO), 1);
            chk("tmo_delay_max", int'(txt[3] - txt[2] <= TMO + 4), 1);
        end
        run_drain("tmo_tail", 50);
        chk("tmo_tail_len", txq.size(), 5);
        txq.delete(); txt.delete();

        push(0, 8'h90); push(0, 8'h3C); drive();
        run_txn("tmo2", 2, 20);
        repeat (TMO + 100) tick();
        chk("tmo2_released", int'(grant_o), 0);
        push(0, 8'h40); push(0, 8'h3E); drive();
        run_drain("tmo2_resume", 50);
        cl = '{8'h90, 8'h3C, 8'h90, 8'h40, 8'h3E};
        cmp_q("tmo2_rs_cleared", cl);

        do_reset();
        for (int p = 0; p < 40; p++) begin
            full_pct = $urandom_range(0, 60);
            for (int k = 0; k < N; k++) repeat ($urandom_range(0, 3)) gen_msg(k);
            drive();
            phase($sformatf("rnd%0d", p), 1'b0);
        end
        full_pct = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
